// File: rtl/i_fetch_pkg.sv
// i_fetch_pkg: shared widths, reset PC and FSM encoding for the fetch stage
package i_fetch_pkg;
   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 32;
   localparam int RESET_PC_DEF = 0;
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/i_fetch_if.sv
// i_fetch_if: control, instruction-memory and decode-side signals of the fetch stage
interface i_fetch_if
   import i_fetch_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic              start;
   logic              stop;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_addr;
   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_instr;
   logic [ADDR_W-1:0] out_pc;
   logic              running;
   logic [15:0]       fetch_count;
   modport master (
      input  start, stop, redirect_valid, redirect_addr, imem_data, out_ready,
      output imem_addr, out_valid, out_instr, out_pc, running, fetch_count
   );
   modport slave (
      output start, stop, redirect_valid, redirect_addr, imem_data, out_ready,
      input  imem_addr, out_valid, out_instr, out_pc, running, fetch_count
   );
endinterface

// File: rtl/i_fetch.sv
// i_fetch: IDLE/RUN instruction fetch from a combinational memory into a
// single valid/ready output register, with redirect flush and handshake count
module i_fetch
   import i_fetch_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int RESET_PC = RESET_PC_DEF
) (
   input logic        clk,
   input logic        rst_n,
   i_fetch_if.master  bus
);
   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic              hs;
   logic              load;
   assign hs = bus.out_valid && bus.out_ready;
   assign load = state == RUN && !bus.redirect_valid && !bus.stop && (!bus.out_valid || bus.out_ready);
   assign bus.imem_addr = pc;
   assign bus.running = state == RUN;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         pc              <= ADDR_W'(RESET_PC);
         bus.out_valid   <= 1'b0;
         bus.out_instr   <= '0;
         bus.out_pc      <= '0;
         bus.fetch_count <= '0;
      end else begin
         state <= bus.stop ? IDLE : bus.start ? RUN : state;
         // redirect wins over load; a handshake in the same cycle still counts below
         if (bus.redirect_valid) begin
            pc            <= bus.redirect_addr;
            bus.out_valid <= 1'b0;
         end else if (load) begin
            bus.out_instr <= bus.imem_data;
            bus.out_pc    <= pc;
            bus.out_valid <= 1'b1;
            pc            <= pc + 1'b1;
         end else if (hs) begin
            bus.out_valid <= 1'b0;
         end
         if (hs && bus.fetch_count != 16'hFFFF)
            bus.fetch_count <= bus.fetch_count + 16'd1;
      end
   end
endmodule

// File: tb/tb_i_fetch.sv
// tb_i_fetch: scoreboard bench for i_fetch; expected (pc, instr) pairs are
// queued as stimulus is set up and popped on every output handshake
module tb_i_fetch;
   typedef struct {logic [7:0] pc; logic [31:0] instr;} exp_t;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] mem [256];
   exp_t        sb [$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          n_hs = 0;
   i_fetch_if #(.ADDR_W(8), .DATA_W(32)) bus ();
   i_fetch #(.ADDR_W(8), .DATA_W(32), .RESET_PC(0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   assign bus.imem_data = mem[bus.imem_addr];
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask
   task automatic push(input int a);
      sb.push_back('{8'(a), mem[a]});
   endtask
   // inputs are already set for the coming edge, so a handshake is visible now
   task automatic step();
      exp_t e;
      if (bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) chk("sb_unexpected", 1, 0);
         else begin
            e = sb.pop_front();
            chk("sb_pc", 32'(bus.out_pc), 32'(e.pc));
            chk("sb_instr", bus.out_instr, e.instr);
         end
         n_hs++;
      end
      @(negedge clk);
   endtask
   task automatic wait_pc(input int a);
      for (int i = 0; i < 20; i++) begin
         if (bus.out_valid && bus.out_pc == 8'(a)) return;
         step();
      end
      chk("wait_pc_timeout", 0, 1);
   endtask
   task automatic redirect(input int a);
      bus.out_ready = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_addr = 8'(a);
      step();
      bus.redirect_valid = 1'b0;
      sb.delete();
   endtask
   initial begin
      mem[0] = 32'h00000000; mem[1] = 32'h00168033; mem[2] = 32'h00168032; mem[3] = 32'h00168031;
      mem[4] = 32'h00168030; mem[5] = 32'h00168031; mem[6] = 32'h00168032; mem[7] = 32'h00168033;
      for (int i = 8; i < 256; i++) mem[i] = 32'hA5000000 | 32'(i);
      rst_n = 1'b0;
      bus.start = 1'b0; bus.stop = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_addr = '0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("rst_valid", 32'(bus.out_valid), 0);
      chk("rst_count", 32'(bus.fetch_count), 0);
      chk("rst_running", 32'(bus.running), 0);
      chk("rst_addr", 32'(bus.imem_addr), 0);
      chk("rst_pc", 32'(bus.out_pc), 0);
      chk("rst_instr", bus.out_instr, 0);
      rst_n = 1'b1;
      step();
      chk("idle_no_fetch", 32'(bus.out_valid), 0);
      // sustained stream 0..7
      for (int i = 0; i < 8; i++) push(i);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("running", 32'(bus.running), 1);
      for (int i = 0; i < 20 && n_hs < 8; i++) step();
      chk("stream_hs", 32'(n_hs), 8);
      chk("count8", 32'(bus.fetch_count), 8);
      // backpressure at pc 2
      redirect(0);
      chk("redir_flush", 32'(bus.out_valid), 0);
      for (int i = 0; i < 4; i++) push(i);
      bus.out_ready = 1'b1;
      wait_pc(2);
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hold_instr", bus.out_instr, 32'h00168032);
         chk("hold_pc", 32'(bus.out_pc), 2);
         chk("hold_addr", 32'(bus.imem_addr), 3);
      end
      bus.out_ready = 1'b1;
      step();
      chk("release_pc", 32'(bus.out_pc), 3);
      chk("release_valid", 32'(bus.out_valid), 1);
      // redirect coinciding with a handshake
      redirect(0);
      for (int i = 0; i < 3; i++) push(i);
      bus.out_ready = 1'b1;
      wait_pc(2);
      bus.redirect_valid = 1'b1;
      bus.redirect_addr = 8'd6;
      step();
      bus.redirect_valid = 1'b0;
      chk("redir_valid", 32'(bus.out_valid), 0);
      chk("redir_addr", 32'(bus.imem_addr), 6);
      chk("redir_count", 32'(bus.fetch_count), 32'(n_hs));
      step();
      chk("redir_out_pc", 32'(bus.out_pc), 6);
      chk("redir_out_instr", bus.out_instr, 32'h00168032);
      // wrap 255 -> 0
      redirect(255);
      push(255);
      push(0);
      bus.out_ready = 1'b1;
      wait_pc(0);
      chk("wrap_instr", bus.out_instr, 32'h00000000);
      chk("wrap_addr", 32'(bus.imem_addr), 1);
      // stop with a pending, un-accepted instruction (pc 0 still queued)
      bus.out_ready = 1'b0;
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
      chk("stop_running", 32'(bus.running), 0);
      chk("stop_held_valid", 32'(bus.out_valid), 1);
      step();
      chk("stop_held_pc", 32'(bus.out_pc), 0);
      bus.out_ready = 1'b1;
      step();
      chk("stop_drained", 32'(bus.out_valid), 0);
      chk("sb_empty", 32'(sb.size()), 0);
      step();
      chk("stop_no_more", 32'(bus.out_valid), 0);
      bus.start = 1'b1;
      bus.stop = 1'b1;
      step();
      bus.start = 1'b0;
      bus.stop = 1'b0;
      chk("start_stop_idle", 32'(bus.running), 0);
      step();
      chk("start_stop_nofetch", 32'(bus.out_valid), 0);
      // asynchronous reset mid-stream
      bus.out_ready = 1'b0;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      chk("pre_rst_valid", 32'(bus.out_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(bus.out_valid), 0);
      chk("arst_count", 32'(bus.fetch_count), 0);
      chk("arst_addr", 32'(bus.imem_addr), 0);
      chk("arst_running", 32'(bus.running), 0);
      @(negedge clk);
      rst_n = 1'b1;
      n_hs = 0;
      sb.delete();
      bus.out_ready = 1'b1;
      repeat (3) step();
      chk("post_rst_idle", 32'(bus.out_valid), 0);
      push(0);
      push(1);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      wait_pc(1);
      chk("post_rst_count", 32'(bus.fetch_count), 1);
      chk("post_rst_instr", bus.out_instr, 32'h00168033);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
